// File: rtl/dtc_share_sched.sv
// dtc_share_sched
//   Time-shares one decision-tree classifier among N_REQ feature producers.
//   A round-robin arbiter picks one requester at a time, the feature is held
//   on cls_inp while the classifier settles (CLS_LAT extra cycles), and the
//   thermometer code coming back is registered together with its decoded
//   class index and a malformed-code flag. The response is held under
//   valid/ready backpressure; delivered responses and delivered errors are
//   counted.
//
// Ports
//   clk, rst      clock (rising edge) and synchronous active-high reset
//   req_valid     per-requester feature valid
//   req_data      packed features, requester i on bits [7*i+6:7*i]
//   req_ready     one-hot accept strobe (IDLE only), else all zero
//   cls_inp       feature presented to the shared classifier
//   cls_outp      thermometer code returned by the classifier
//   resp_valid    response available
//   resp_ready    response consumer ready
//   resp_id       index of the requester the response belongs to
//   resp_code     raw classifier code
//   resp_class    number of ones in resp_code
//   resp_err      resp_code is not of the form 0..01..1
//   busy          scheduler is not idle
//   cnt_done      delivered responses, wrapping
//   cnt_err       delivered responses with resp_err set, saturating
module dtc_share_sched #(
    parameter int N_REQ   = 4,
    parameter int CLS_LAT = 0,
    parameter int CNT_W   = 16,
    localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*7-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [6:0]         cls_inp,
    input  logic [6:0]         cls_outp,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [6:0]         resp_code,
    output logic [2:0]         resp_class,
    output logic               resp_err,
    output logic               busy,
    output logic [CNT_W-1:0]   cnt_done,
    output logic [CNT_W-1:0]   cnt_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic [6:0]     win_data;
    logic [6:0]     in_reg;
    logic [2:0]     wait_cnt;
    int             scan_idx;

    // Number of ones in a 7-bit code.
    function automatic logic [2:0] popcount7(input logic [6:0] c);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 7; i++) begin
            n = n + {2'b00, c[i]};
        end
        return n;
    endfunction

    // A legal thermometer code is 0..01..1; adding one to it yields a single
    // power of two with no bits in common with the code itself.
    function automatic logic thermo_err(input logic [6:0] c);
        return (c & (c + 7'd1)) != 7'd0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Round-robin scan: walking the distances from N_REQ down to 1 lets the
    // nearest valid requester after last_grant overwrite any farther one.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            scan_idx = (int'(last_grant) + k) % N_REQ;
            if (req_valid[IDW'(scan_idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(scan_idx);
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == IDW'(i)) begin
                win_data = req_data[7*i +: 7];
            end
        end
    end

    // The accept strobe is suppressed while reset is asserted so that no
    // handshake can appear to complete in a cycle that is being discarded.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign cls_inp    = in_reg;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(N_REQ - 1);
            in_reg     <= '0;
            wait_cnt   <= '0;
            resp_id    <= '0;
            resp_code  <= '0;
            resp_class <= '0;
            resp_err   <= 1'b0;
            cnt_done   <= '0;
            cnt_err    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        in_reg     <= win_data;
                        resp_id    <= win_id;
                        last_grant <= win_id;
                        wait_cnt   <= '0;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    // cls_outp is trusted only once the classifier pipeline
                    // has seen the held feature for CLS_LAT full cycles.
                    if (wait_cnt == 3'(CLS_LAT)) begin
                        resp_code  <= cls_outp;
                        resp_class <= popcount7(cls_outp);
                        resp_err   <= thermo_err(cls_outp);
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        cnt_done <= cnt_done + CNT_W'(1);
                        if (resp_err) begin
                            cnt_err <= sat_inc(cnt_err);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dtc_share_sched.sv
module tb_dtc_share_sched;

    logic        clk;
    logic        rs   [2];
    logic [3:0]  rv   [2];
    logic [27:0] rd   [2];
    logic [3:0]  rr   [2];
    logic [6:0]  ci   [2];
    logic [6:0]  co   [2];
    logic        rvld [2];
    logic        rrdy [2];
    logic [1:0]  rid  [2];
    logic [6:0]  rcode[2];
    logic [2:0]  rcls [2];
    logic        rerr [2];
    logic        bsy  [2];
    logic [3:0]  cdone[2];
    logic [3:0]  cerr [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state per unit (unit 0: CLS_LAT=0, unit 1: CLS_LAT=3)
    bit         armed [2];
    bit         m_busy[2];
    int         m_last[2];
    int         m_acc [2];
    int         m_id  [2];
    logic [6:0] m_code[2];
    int         m_done[2];
    int         m_errc[2];

    dtc_share_sched #(.N_REQ(4), .CLS_LAT(0), .CNT_W(4)) u0 (
        .clk(clk), .rst(rs[0]), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr[0]),
        .cls_inp(ci[0]), .cls_outp(co[0]), .resp_valid(rvld[0]), .resp_ready(rrdy[0]),
        .resp_id(rid[0]), .resp_code(rcode[0]), .resp_class(rcls[0]), .resp_err(rerr[0]),
        .busy(bsy[0]), .cnt_done(cdone[0]), .cnt_err(cerr[0]));

    dtc_share_sched #(.N_REQ(4), .CLS_LAT(3), .CNT_W(4)) u3 (
        .clk(clk), .rst(rs[1]), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr[1]),
        .cls_inp(ci[1]), .cls_outp(co[1]), .resp_valid(rvld[1]), .resp_ready(rrdy[1]),
        .resp_id(rid[1]), .resp_code(rcode[1]), .resp_class(rcls[1]), .resp_err(rerr[1]),
        .busy(bsy[1]), .cnt_done(cdone[1]), .cnt_err(cerr[1]));

    // Classifier stub: threshold tree on the feature value, plus two
    // deliberately malformed outputs at the top of the range.
    function automatic logic [6:0] tree(input logic [6:0] f);
        int c;
        if (f == 7'h7F) return 7'b0100000;
        if (f >= 7'd124) return 7'b1010101;
        c = (f < 16) ? 6 : (f < 32) ? 5 : (f < 64) ? 4 : (f < 96) ? 3 :
            (f < 112) ? 2 : (f < 120) ? 1 : 0;
        return 7'((1 << c) - 1);
    endfunction

    logic [6:0] d1, d2, d3;
    assign co[0] = tree(ci[0]);
    always @(posedge clk) begin
        d1 <= tree(ci[1]);
        d2 <= d1;
        d3 <= d2;
    end
    assign co[1] = d3;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input int u, input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL u%0d %s: got %0d want %0d (cycle %0d)", u, nm, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: who should win, when the response is due,
    // what it must contain, and what the counters must read.
    task automatic mon(input int u);
        int lat, w, idx, cls;
        logic [3:0] er;
        bit due;
        lat = (u == 0) ? 0 : 3;
        w = -1;
        due = 0;
        for (int k = 1; k <= 4; k++) begin
            idx = (m_last[u] + k) % 4;
            if (w < 0 && rv[u][idx]) w = idx;
        end
        if (armed[u]) begin
            er = (!m_busy[u] && !rs[u] && w >= 0) ? 4'(1 << w) : 4'd0;
            chk(u, "req_ready", rr[u], er);
            chk(u, "busy", bsy[u], m_busy[u]);
            due = m_busy[u] && (cyc >= m_acc[u] + 2 + lat);
            chk(u, "resp_valid", rvld[u], due);
            if (due) begin
                cls = $countones(m_code[u]);
                chk(u, "resp_id", rid[u], m_id[u]);
                chk(u, "resp_code", rcode[u], m_code[u]);
                chk(u, "resp_class", rcls[u], cls);
                chk(u, "resp_err", rerr[u], (int'(m_code[u]) != (1 << cls) - 1));
            end
            chk(u, "cnt_done", cdone[u], m_done[u]);
            chk(u, "cnt_err", cerr[u], m_errc[u]);
        end
        if (rs[u]) begin
            armed[u]  = 1;
            m_busy[u] = 0;
            m_last[u] = 3;
            m_done[u] = 0;
            m_errc[u] = 0;
        end else if (armed[u]) begin
            if (!m_busy[u] && w >= 0) begin
                m_busy[u] = 1;
                m_last[u] = w;
                m_id[u]   = w;
                m_acc[u]  = cyc;
                m_code[u] = tree(rd[u][7*w +: 7]);
            end else if (due && rrdy[u]) begin
                m_busy[u] = 0;
                m_done[u] = (m_done[u] + 1) % 16;
                if (int'(m_code[u]) != (1 << $countones(m_code[u])) - 1)
                    m_errc[u] = (m_errc[u] < 15) ? m_errc[u] + 1 : 15;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) mon(u);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int u);
        int n;
        n = 0;
        @(negedge clk);
        while (bsy[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(u, "idle_wait", bsy[u], 0);
    endtask

    task automatic do_txn(input int u, input int r, input logic [6:0] f,
                          input logic [6:0] ecode, input int ecls, input int eerr);
        int n, c, lat;
        lat = (u == 0) ? 0 : 3;
        wait_idle(u);
        tick();
        rv[u] = 4'(1 << r);
        rd[u][7*r +: 7] = f;
        n = 0;
        @(negedge clk);
        while (!rr[u][r] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(u, "accept", rr[u][r], 1);
        c = cyc;
        tick();
        rv[u] = 4'd0;
        n = 0;
        @(negedge clk);
        while (!rvld[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(u, "resp_wait", rvld[u], 1);
        if (rvld[u]) begin
            chk(u, "latency", cyc - c, 2 + lat);
            chk(u, "t_id", rid[u], r);
            chk(u, "t_code", rcode[u], ecode);
            chk(u, "t_class", rcls[u], ecls);
            chk(u, "t_err", rerr[u], eerr);
        end
    endtask

    typedef struct {
        int         req;
        logic [6:0] feat;
        logic [6:0] code;
        int         cls;
        int         err;
    } vec_t;

    vec_t tbl[10];
    int   grants[$];
    int   resps[$];
    int   sid, scode, sdone, n;

    initial begin
        tbl[0] = '{1, 7'd0,   7'b0111111, 6, 0};
        tbl[1] = '{1, 7'd80,  7'b0000111, 3, 0};
        tbl[2] = '{2, 7'd127, 7'b0100000, 1, 1};
        tbl[3] = '{0, 7'd20,  7'b0011111, 5, 0};
        tbl[4] = '{3, 7'd50,  7'b0001111, 4, 0};
        tbl[5] = '{2, 7'd100, 7'b0000011, 2, 0};
        tbl[6] = '{0, 7'd115, 7'b0000001, 1, 0};
        tbl[7] = '{3, 7'd122, 7'b0000000, 0, 0};
        tbl[8] = '{1, 7'd125, 7'b1010101, 4, 1};
        tbl[9] = '{0, 7'd15,  7'b0111111, 6, 0};

        for (int u = 0; u < 2; u++) begin
            rs[u] = 1'b1; rv[u] = 4'hF; rd[u] = '0; rrdy[u] = 1'b1;
            armed[u] = 0; m_busy[u] = 0; m_last[u] = 3; m_done[u] = 0; m_errc[u] = 0;
        end

        // reset with every requester asking
        tick();
        tick();
        chk(0, "rst_req_ready", rr[0], 0);
        chk(0, "rst_resp_valid", rvld[0], 0);
        chk(0, "rst_busy", bsy[0], 0);
        chk(0, "rst_resp_id", rid[0], 0);
        chk(0, "rst_resp_code", rcode[0], 0);
        chk(0, "rst_resp_class", rcls[0], 0);
        chk(0, "rst_resp_err", rerr[0], 0);
        chk(0, "rst_cls_inp", ci[0], 0);
        chk(0, "rst_cnt_done", cdone[0], 0);
        chk(0, "rst_cnt_err", cerr[0], 0);
        rs[0] = 1'b0; rs[1] = 1'b0; rv[1] = 4'd0;

        // all requesters held valid: strict rotation, one response per 3 cycles
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (rr[0] != 4'd0) begin
                chk(0, "grant_onehot", $onehot(rr[0]), 1);
                for (int k = 0; k < 4; k++) if (rr[0][k]) grants.push_back(k);
            end
            if (rvld[0]) resps.push_back(cyc);
        end
        tick();
        rv[0] = 4'd0;
        chk(0, "grant_count", grants.size(), 5);
        if (grants.size() == 5) begin
            chk(0, "grant0", grants[0], 0);
            chk(0, "grant1", grants[1], 1);
            chk(0, "grant2", grants[2], 2);
            chk(0, "grant3", grants[3], 3);
            chk(0, "grant4", grants[4], 0);
        end
        chk(0, "resp_count", resps.size(), 4);
        for (int i = 1; i < resps.size(); i++) chk(0, "resp_spacing", resps[i] - resps[i-1], 3);

        // stimulus table
        for (int i = 0; i < 10; i++) begin
            do_txn(0, tbl[i].req, tbl[i].feat, tbl[i].code, tbl[i].cls, tbl[i].err);
            if (i == 2) begin
                @(negedge clk);
                chk(0, "first_err_count", cerr[0], 1);
            end
        end

        // backpressure with other requests pending
        wait_idle(0);
        tick();
        rrdy[0] = 1'b0;
        rv[0] = 4'hF;
        rd[0] = 28'($urandom);
        n = 0;
        @(negedge clk);
        while (!rvld[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(0, "bp_resp_wait", rvld[0], 1);
        sid = rid[0]; scode = rcode[0]; sdone = cdone[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(0, "bp_valid", rvld[0], 1);
            chk(0, "bp_id", rid[0], sid);
            chk(0, "bp_code", rcode[0], scode);
            chk(0, "bp_req_ready", rr[0], 0);
            chk(0, "bp_cnt_done", cdone[0], sdone);
        end
        tick();
        rrdy[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk(0, "bp_release_cnt", cdone[0], (sdone + 1) % 16);
        tick();
        rv[0] = 4'd0;

        // malformed codes until the error counter saturates
        for (int i = 0; i < 17; i++) do_txn(0, i % 4, 7'h7F, 7'b0100000, 1, 1);
        @(negedge clk);
        chk(0, "err_saturated", cerr[0], 15);

        // CLS_LAT=3: normal latency, then reset in the 2nd EVAL cycle
        do_txn(1, 2, 7'd40, 7'b0001111, 4, 0);
        wait_idle(1);
        tick();
        rv[1] = 4'b0010;
        rd[1][13:7] = 7'd33;
        n = 0;
        @(negedge clk);
        while (!rr[1][1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(1, "abort_accept", rr[1][1], 1);
        tick();
        rv[1] = 4'd0;
        tick();
        rs[1] = 1'b1;
        tick();
        rs[1] = 1'b0;
        @(negedge clk);
        chk(1, "abort_busy", bsy[1], 0);
        chk(1, "abort_cnt_done", cdone[1], 0);
        chk(1, "abort_cnt_err", cerr[1], 0);
        for (int i = 0; i < 8; i++) begin
            chk(1, "abort_no_resp", rvld[1], 0);
            @(negedge clk);
        end

        // random traffic on both units against the reference model
        for (int i = 0; i < 3000; i++) begin
            tick();
            for (int u = 0; u < 2; u++) begin
                rv[u]   = 4'($urandom) & 4'($urandom);
                rd[u]   = 28'($urandom);
                rrdy[u] = ($urandom % 4) != 0;
                rs[u]   = ($urandom % 300) == 0;
            end
        end
        tick();
        for (int u = 0; u < 2; u++) begin
            rs[u] = 1'b0; rv[u] = 4'd0; rrdy[u] = 1'b1;
        end
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
